// File: rtl/sid_pkg.sv
// Shared constants and helpers for the SID bus responder.
package sid_pkg;

    localparam logic [4:0] SID_POTX  = 5'h19;
    localparam logic [4:0] SID_POTY  = 5'h1A;
    localparam logic [4:0] SID_OSC3  = 5'h1B;
    localparam logic [4:0] SID_ENV3  = 5'h1C;
    localparam int         SID_NREGS = 29;

    localparam int SID_DECAY_CYCLES_DEF = 8192;

    // True for the four engine-driven read-only registers.
    function automatic logic sid_is_ro(input logic [4:0] addr);
        return (addr >= SID_POTX) && (addr <= SID_ENV3);
    endfunction

endpackage

// File: rtl/sid_sync.sv
// Multi-flop synchroniser for one asynchronous control bit; resets to the idle level (1).
module sid_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/sid_bus_slave.sv
// SID-side bus responder: turns phi2-timed CPLD bus cycles into clk32 write/read
// strobes, serves the read-only registers and emulates the decaying data-bus latch.
module sid_bus_slave
    import sid_pkg::*;
#(
    parameter int DECAY_CYCLES = SID_DECAY_CYCLES_DEF,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk32,
    input  logic       rst,
    input  logic       sid_clk,
    input  logic       sid_cs,
    input  logic       sid_wr,
    input  logic [4:0] sid_a,
    input  logic [7:0] sid_d_in,
    output logic [7:0] sid_d_out,
    output logic       sid_d_oe,
    output logic       wr_stb,
    output logic [4:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       rd_stb,
    input  logic [7:0] potx,
    input  logic [7:0] poty,
    input  logic [7:0] osc3,
    input  logic [7:0] env3
);

    localparam int            CW       = $clog2(DECAY_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DECAY_CYCLES - 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          s_clk, s_cs, s_wr;
    logic          clk_prev_q, armed_q;
    logic [1:0]    settle_q;
    logic          settle_done_s, fall_ev_s, acc_wr_s, acc_rd_s;
    logic [7:0]    rd_mux_s;
    logic [7:0]    bus_latch_q, bus_latch_d;
    logic [CW-1:0] decay_cnt_q, decay_cnt_d;
    logic          wr_stb_q, rd_stb_q, oe_q;
    logic [4:0]    wr_addr_q;
    logic [7:0]    wr_data_q, dout_q;

    sid_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (.clk_i(clk32), .rst_i(rst), .d_i(sid_clk), .q_o(s_clk));
    sid_sync #(.STAGES(SYNC_STAGES)) u_sync_cs  (.clk_i(clk32), .rst_i(rst), .d_i(sid_cs),  .q_o(s_cs));
    sid_sync #(.STAGES(SYNC_STAGES)) u_sync_wr  (.clk_i(clk32), .rst_i(rst), .d_i(sid_wr),  .q_o(s_wr));

    // Falls are only trusted once the synchronisers carry real data and phi2 was seen high,
    // so a low phi2 at reset release cannot masquerade as an edge.
    assign settle_done_s = (settle_q == 2'(SYNC_STAGES));
    assign fall_ev_s     = armed_q & clk_prev_q & ~s_clk;
    assign acc_wr_s      = fall_ev_s & ~s_cs & ~s_wr;
    assign acc_rd_s      = fall_ev_s & ~s_cs &  s_wr;

    // Read data source selected by the current address.
    always_comb begin
        rd_mux_s = bus_latch_q;
        case (sid_a)
            SID_POTX: rd_mux_s = potx;
            SID_POTY: rd_mux_s = poty;
            SID_OSC3: rd_mux_s = osc3;
            SID_ENV3: rd_mux_s = env3;
            default:  rd_mux_s = bus_latch_q;
        endcase
    end

    // Bus latch and decay counter next state; an access always beats expiry.
    always_comb begin
        bus_latch_d = bus_latch_q;
        decay_cnt_d = decay_cnt_q;
        if (acc_wr_s) begin
            bus_latch_d = sid_d_in;
            decay_cnt_d = '0;
        end else if (acc_rd_s) begin
            if (sid_is_ro(sid_a)) begin
                bus_latch_d = rd_mux_s;
            end else begin
                bus_latch_d = bus_latch_q;
            end
            decay_cnt_d = '0;
        end else if (fall_ev_s) begin
            if (decay_cnt_q == CNT_LAST) begin
                bus_latch_d = 8'h00;
                decay_cnt_d = '0;
            end else begin
                decay_cnt_d = decay_cnt_q + CNT_ONE;
            end
        end else begin
            bus_latch_d = bus_latch_q;
            decay_cnt_d = decay_cnt_q;
        end
    end

    // Registered strobes, bus outputs, latch state and edge history.
    always_ff @(posedge clk32) begin
        if (rst) begin
            wr_stb_q    <= 1'b0;
            rd_stb_q    <= 1'b0;
            wr_addr_q   <= 5'h00;
            wr_data_q   <= 8'h00;
            dout_q      <= 8'h00;
            oe_q        <= 1'b0;
            bus_latch_q <= 8'h00;
            decay_cnt_q <= '0;
            clk_prev_q  <= 1'b1;
            armed_q     <= 1'b0;
            settle_q    <= 2'd0;
        end else begin
            wr_stb_q    <= acc_wr_s;
            rd_stb_q    <= acc_rd_s;
            if (acc_wr_s) begin
                wr_addr_q <= sid_a;
                wr_data_q <= sid_d_in;
            end
            dout_q      <= rd_mux_s;
            oe_q        <= ~s_cs & s_wr;
            bus_latch_q <= bus_latch_d;
            decay_cnt_q <= decay_cnt_d;
            clk_prev_q  <= s_clk;
            if (!settle_done_s) begin
                settle_q <= settle_q + 2'd1;
            end
            if (settle_done_s && s_clk) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign wr_stb    = wr_stb_q;
    assign rd_stb    = rd_stb_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign sid_d_out = dout_q;
    assign sid_d_oe  = oe_q;

endmodule

// File: tb/tb_sid_bus_slave.sv
// Directed bench for sid_bus_slave: vector table of full phi2 cycles plus hand sequences.
module tb_sid_bus_slave;

    logic       clk32 = 1'b0;
    logic       rst = 1'b1;
    logic       sid_clk = 1'b1;
    logic       sid_cs = 1'b1;
    logic       sid_wr = 1'b1;
    logic [4:0] sid_a = 5'h00;
    logic [7:0] sid_d_in = 8'h00;
    logic [7:0] potx = 8'hA5, poty = 8'h3C, osc3 = 8'h81, env3 = 8'h7E;
    logic [7:0] sid_d_out;
    logic       sid_d_oe, wr_stb, rd_stb;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int last_stb_cyc = 0;
    int fall_cyc = 0;
    logic [4:0] last_addr = 5'h00;
    logic [7:0] last_data = 8'h00;
    logic [4:0] addr_q[$];

    sid_bus_slave #(.DECAY_CYCLES(16), .SYNC_STAGES(2)) dut (
        .clk32(clk32), .rst(rst), .sid_clk(sid_clk), .sid_cs(sid_cs), .sid_wr(sid_wr),
        .sid_a(sid_a), .sid_d_in(sid_d_in), .sid_d_out(sid_d_out), .sid_d_oe(sid_d_oe),
        .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .rd_stb(rd_stb),
        .potx(potx), .poty(poty), .osc3(osc3), .env3(env3)
    );

    always #15 clk32 = ~clk32;

    always @(posedge clk32) cyc <= cyc + 1;

    // Strobe monitor, sampled on the inactive edge.
    always @(negedge clk32) begin
        if (wr_stb === 1'b1) begin
            wr_cnt++;
            last_addr = wr_addr;
            last_data = wr_data;
            addr_q.push_back(wr_addr);
            last_stb_cyc = cyc;
        end
        if (rd_stb === 1'b1) begin
            rd_cnt++;
            last_stb_cyc = cyc;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One full phi2 period; dout/oe are sampled just before the falling edge.
    task automatic phi2_cycle(input logic cs, input logic wr, input logic [4:0] a, input logic [7:0] d,
                              output logic [7:0] dout, output logic oe,
                              output int nwr, output int nrd, output int lat);
        int w0;
        int r0;
        @(negedge clk32);
        sid_cs = cs; sid_wr = wr; sid_a = a; sid_d_in = d; sid_clk = 1'b1;
        repeat (8) @(negedge clk32);
        dout = sid_d_out;
        oe = sid_d_oe;
        w0 = wr_cnt;
        r0 = rd_cnt;
        sid_clk = 1'b0;
        fall_cyc = cyc;
        repeat (8) @(negedge clk32);
        nwr = wr_cnt - w0;
        nrd = rd_cnt - r0;
        lat = last_stb_cyc - fall_cyc;
        sid_cs = 1'b1;
        sid_wr = 1'b1;
    endtask

    typedef struct {
        logic       cs;
        logic       wr;
        logic [4:0] a;
        logic [7:0] d;
        int         exp_wr;
        int         exp_rd;
        logic [7:0] exp_dout;
        logic       exp_oe;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [7:0] dout;
        logic       oe;
        int         nwr, nrd, lat, w0, r0;

        vecs[0]  = '{1'b0, 1'b0, 5'h18, 8'h0F, 1, 0, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 5'h19, 8'h00, 0, 1, 8'hA5, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 5'h04, 8'h00, 0, 1, 8'hA5, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 5'h1A, 8'h00, 0, 1, 8'h3C, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 5'h1B, 8'h00, 0, 1, 8'h81, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 5'h1C, 8'h00, 0, 1, 8'h7E, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 5'h1D, 8'h00, 0, 1, 8'h7E, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 5'h1F, 8'h00, 0, 0, 8'h7E, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 5'h04, 8'h5A, 1, 0, 8'h7E, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 5'h04, 8'h00, 0, 1, 8'h5A, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 5'h1C, 8'hC3, 1, 0, 8'h7E, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 5'h00, 8'h00, 0, 1, 8'hC3, 1'b1};

        // Reset state
        repeat (4) @(negedge clk32);
        chk("rst_wr_stb", wr_stb, 1'b0);
        chk("rst_rd_stb", rd_stb, 1'b0);
        chk("rst_wr_addr", wr_addr, 5'h00);
        chk("rst_wr_data", wr_data, 8'h00);
        chk("rst_dout", sid_d_out, 8'h00);
        chk("rst_oe", sid_d_oe, 1'b0);
        rst = 1'b0;
        repeat (6) @(negedge clk32);
        chk("post_rst_strobes", wr_cnt + rd_cnt, 0);

        // Vector table
        for (int i = 0; i < 12; i++) begin
            phi2_cycle(vecs[i].cs, vecs[i].wr, vecs[i].a, vecs[i].d, dout, oe, nwr, nrd, lat);
            chk($sformatf("v%0d_dout", i), dout, vecs[i].exp_dout);
            chk($sformatf("v%0d_oe", i), oe, vecs[i].exp_oe);
            chk($sformatf("v%0d_nwr", i), nwr, vecs[i].exp_wr);
            chk($sformatf("v%0d_nrd", i), nrd, vecs[i].exp_rd);
            if (vecs[i].exp_wr == 1) begin
                chk($sformatf("v%0d_wr_addr", i), last_addr, vecs[i].a);
                chk($sformatf("v%0d_wr_data", i), last_data, vecs[i].d);
            end
            if (vecs[i].exp_wr + vecs[i].exp_rd == 1) begin
                chk($sformatf("v%0d_latency", i), lat, 3);
            end
        end

        // oe release after a read: still high 2 cycles after cs rises, low on the third
        phi2_cycle(1'b0, 1'b1, 5'h19, 8'h00, dout, oe, nwr, nrd, lat);
        @(negedge clk32);
        @(negedge clk32);
        chk("oe_hold", sid_d_oe, 1'b1);
        @(negedge clk32);
        chk("oe_release", sid_d_oe, 1'b0);

        // Decay: 14 idle falls keep the latch, 15 clear it
        phi2_cycle(1'b0, 1'b0, 5'h04, 8'h5A, dout, oe, nwr, nrd, lat);
        repeat (14) phi2_cycle(1'b1, 1'b1, 5'h04, 8'h00, dout, oe, nwr, nrd, lat);
        phi2_cycle(1'b0, 1'b1, 5'h04, 8'h00, dout, oe, nwr, nrd, lat);
        chk("decay_14_keep", dout, 8'h5A);
        repeat (15) phi2_cycle(1'b1, 1'b1, 5'h04, 8'h00, dout, oe, nwr, nrd, lat);
        phi2_cycle(1'b0, 1'b1, 5'h04, 8'h00, dout, oe, nwr, nrd, lat);
        chk("decay_15_clear", dout, 8'h00);

        // Write landing on the expiry fall wins
        phi2_cycle(1'b0, 1'b0, 5'h04, 8'h33, dout, oe, nwr, nrd, lat);
        repeat (14) phi2_cycle(1'b1, 1'b1, 5'h04, 8'h00, dout, oe, nwr, nrd, lat);
        phi2_cycle(1'b0, 1'b0, 5'h08, 8'h77, dout, oe, nwr, nrd, lat);
        chk("expiry_write_stb", nwr, 1);
        phi2_cycle(1'b0, 1'b1, 5'h04, 8'h00, dout, oe, nwr, nrd, lat);
        chk("expiry_write_latch", dout, 8'h77);

        // Short cs-low pulses without a phi2 fall
        w0 = wr_cnt;
        r0 = rd_cnt;
        @(negedge clk32);
        sid_clk = 1'b1; sid_cs = 1'b0; sid_wr = 1'b0; sid_a = 5'h02; sid_d_in = 8'hEE;
        repeat (10) @(negedge clk32);
        sid_cs = 1'b1; sid_wr = 1'b1;
        repeat (10) @(negedge clk32);
        sid_cs = 1'b0;
        repeat (10) @(negedge clk32);
        sid_cs = 1'b1;
        repeat (10) @(negedge clk32);
        chk("short_cs_wr", wr_cnt - w0, 0);
        chk("short_cs_rd", rd_cnt - r0, 0);

        // Back-to-back writes on consecutive falls
        addr_q.delete();
        for (int i = 0; i < 4; i++) begin
            phi2_cycle(1'b0, 1'b0, 5'(i), 8'(8'h10 + i), dout, oe, nwr, nrd, lat);
        end
        chk("b2b_count", addr_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (addr_q.size() > 0) begin
                chk($sformatf("b2b_addr%0d", i), addr_q.pop_front(), 5'(i));
            end
        end

        // Reset in the middle of a read, released with phi2 low
        @(negedge clk32);
        sid_cs = 1'b0; sid_wr = 1'b1; sid_a = 5'h19; sid_clk = 1'b1;
        repeat (8) @(negedge clk32);
        chk("mid_oe_before", sid_d_oe, 1'b1);
        rst = 1'b1;
        @(negedge clk32);
        chk("mid_rst_oe", sid_d_oe, 1'b0);
        chk("mid_rst_dout", sid_d_out, 8'h00);
        sid_clk = 1'b0;
        repeat (3) @(negedge clk32);
        w0 = wr_cnt;
        r0 = rd_cnt;
        rst = 1'b0;
        repeat (12) @(negedge clk32);
        chk("mid_rst_no_stb", (wr_cnt - w0) + (rd_cnt - r0), 0);
        sid_clk = 1'b1;
        repeat (8) @(negedge clk32);
        sid_clk = 1'b0;
        repeat (8) @(negedge clk32);
        chk("mid_rst_genuine_rd", rd_cnt - r0, 1);
        chk("mid_rst_genuine_wr", wr_cnt - w0, 0);
        sid_cs = 1'b1;
        repeat (4) @(negedge clk32);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
